// File: rtl/ntt_dmem_writeback.sv
// Packs the NTT store-out coefficient stream four lanes per 64-bit word and
// writes the words to data memory through a small FIFO that honours back-pressure.
module ntt_dmem_writeback #(
  parameter int COEF_W     = 16,
  parameter int N_COEF     = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              arm,
  input  logic [63:0]       base_addr,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef_data,
  output logic              dmem_we,
  output logic [63:0]       dmem_addr,
  output logic [63:0]       dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int N_WORD = N_COEF / 4;
  localparam int CNT_W  = $clog2(N_COEF);
  localparam int IDX_W  = CNT_W - 2;
  localparam int WIDX_W = IDX_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WORD_W = 4 * COEF_W;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [63:0]         base_reg;
  logic [CNT_W-1:0]    coef_cnt_reg;
  logic [WIDX_W-1:0]   word_idx_reg;
  logic                overflow_reg;
  logic [WORD_W-1:0]   pack_reg;
  wire  [WORD_W-1:0]   pack_next;
  logic                push_reg;
  logic [WORD_W-1:0]   push_word_reg;
  logic [IDX_W-1:0]    push_idx_reg;
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]      fifo_cnt_reg;

  // Each FIFO entry carries its own word index so a dropped word leaves a hole
  // in the address sequence instead of shifting later words down.
  logic [WORD_W-1:0]   mem_data [FIFO_DEPTH];
  logic [IDX_W-1:0]    mem_idx  [FIFO_DEPTH];

  logic take, lane3_take, last_coef, fifo_full, pop, drop, fifo_wr;

  assign take       = (state_reg == COLLECT) && coef_valid;
  assign lane3_take = take && (coef_cnt_reg[1:0] == 2'd3);
  assign last_coef  = (coef_cnt_reg == CNT_W'(N_COEF - 1));
  assign fifo_full  = (fifo_cnt_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign pop        = dmem_we && dmem_ready;
  assign drop       = push_reg && fifo_full && !pop;
  assign fifo_wr    = push_reg && !drop;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign pack_next[gi*COEF_W +: COEF_W] =
      (take && coef_cnt_reg[1:0] == 2'(gi)) ? coef_data : pack_reg[gi*COEF_W +: COEF_W];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arm) state_next = COLLECT;
      COLLECT: if (coef_valid && last_coef) state_next = DRAIN;
      DRAIN:   if (fifo_cnt_reg == '0 && word_idx_reg == WIDX_W'(N_WORD)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      coef_cnt_reg  <= '0;
      word_idx_reg  <= '0;
      overflow_reg  <= 1'b0;
      pack_reg      <= '0;
      push_reg      <= 1'b0;
      push_word_reg <= '0;
      push_idx_reg  <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fifo_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      push_reg  <= lane3_take;
      if (take) begin
        coef_cnt_reg <= coef_cnt_reg + CNT_W'(1);
        pack_reg     <= pack_next;
      end
      if (lane3_take) begin
        push_word_reg <= pack_next;
        push_idx_reg  <= coef_cnt_reg[CNT_W-1:2];
      end
      if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (fifo_wr && !pop)
        fifo_cnt_reg <= fifo_cnt_reg + (PTR_W+1)'(1);
      else if (!fifo_wr && pop)
        fifo_cnt_reg <= fifo_cnt_reg - (PTR_W+1)'(1);
      if (pop || drop) word_idx_reg <= word_idx_reg + WIDX_W'(1);
      if (drop) overflow_reg <= 1'b1;
      // The FIFO is always empty in IDLE, so clearing word_idx here cannot lose a pop.
      if (state_reg == IDLE && arm) begin
        base_reg     <= base_addr & ~64'h7;
        coef_cnt_reg <= '0;
        word_idx_reg <= '0;
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (fifo_wr) begin
      mem_data[wr_ptr_reg] <= push_word_reg;
      mem_idx[wr_ptr_reg]  <= push_idx_reg;
    end
  end

  assign dmem_we    = (fifo_cnt_reg != '0);
  assign dmem_wstrb = {8{dmem_we}};
  assign dmem_addr  = dmem_we ? base_reg + {{(64-IDX_W-3){1'b0}}, mem_idx[rd_ptr_reg], 3'b000} : 64'd0;
  assign dmem_wdata = dmem_we ? 64'(mem_data[rd_ptr_reg]) : 64'd0;
  assign busy       = (state_reg == COLLECT) || (state_reg == DRAIN);
  assign done       = (state_reg == DONE);
  assign overflow   = overflow_reg;

endmodule
